// File: rtl/alu_retire_stage.sv
// rtl/alu_retire_stage.sv - ALU retire buffer with architectural and speculative EFLAGS
module alu_retire_stage #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] EFLAGS_RST = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [31:0] in_flags,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_dst,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_dst,
    output logic        wb_we,
    input  logic        flush,
    output logic [31:0] eflags,
    output logic        cf_fwd,
    output logic        af_fwd
);
    // OF SF ZF AF PF CF for arithmetic/logic ops; DF alone for CLD/STD
    localparam logic [31:0] ARITH_MASK = 32'h0000_08D5;
    localparam logic [31:0] DF_MASK    = 32'h0000_0400;
    localparam logic [31:0] RSVD_ONE   = 32'h0000_0002;

    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] res_q [2];
    logic [31:0] flg_q [2];
    logic [31:0] msk_q [2];
    logic [2:0]  dst_q [2];
    logic        we_q  [2];
    logic [31:0] spec_q;
    logic [31:0] eflags_q;
    logic [31:0] in_mask;
    logic        in_we;
    logic [31:0] eflags_nxt;
    logic [31:0] spec_merge;
    logic        accept;
    logic        retire;

    assign in_ready = (count != 2'(DEPTH));
    assign wb_valid = (count != 2'd0);
    assign accept   = in_valid & in_ready;
    assign retire   = wb_valid & wb_ready;
    assign wb_data  = res_q[head];
    assign wb_dst   = dst_q[head];
    assign wb_we    = we_q[head];
    assign eflags   = eflags_q;
    assign cf_fwd   = spec_q[0];
    assign af_fwd   = spec_q[4];

    // Decode which EFLAGS bits the incoming op owns and whether it writes a GPR
    always_comb begin
        in_mask = ARITH_MASK;
        in_we   = 1'b1;
        case (in_op)
            3'd2:    in_mask = 32'h0;
            3'd5:    begin in_mask = DF_MASK; in_we = 1'b0; end
            3'd6:    in_we   = 1'b0;
            3'd7:    begin in_mask = DF_MASK; in_we = 1'b0; end
            default: in_mask = ARITH_MASK;
        endcase
    end

    // Next architectural and speculative flag values; bit1 is forced high
    always_comb begin
        eflags_nxt = eflags_q;
        if (retire) begin
            eflags_nxt = (eflags_q & ~msk_q[head]) | (flg_q[head] & msk_q[head]) | RSVD_ONE;
        end
        spec_merge = (spec_q & ~in_mask) | (in_flags & in_mask) | RSVD_ONE;
    end

    // Entry storage, pointers and occupancy; flush empties the buffer and drops a same-cycle accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                res_q[i] <= 32'h0;
                flg_q[i] <= 32'h0;
                msk_q[i] <= 32'h0;
                dst_q[i] <= 3'd0;
                we_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (accept) begin
                res_q[tail] <= in_result;
                flg_q[tail] <= in_flags;
                msk_q[tail] <= in_mask;
                dst_q[tail] <= in_dst;
                we_q[tail]  <= in_we;
                tail        <= ~tail;
            end
            if (retire) begin
                head <= ~head;
            end
            count <= count + 2'(accept) - 2'(retire);
        end
    end

    // EFLAGS copies: retire commits architecturally; accept updates speculation; flush resyncs speculation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eflags_q <= EFLAGS_RST;
            spec_q   <= EFLAGS_RST;
        end else begin
            eflags_q <= eflags_nxt;
            if (flush) begin
                spec_q <= eflags_nxt;
            end else if (accept) begin
                spec_q <= spec_merge;
            end
        end
    end
endmodule

// File: tb/tb_alu_retire_stage.sv
// tb/tb_alu_retire_stage.sv - scoreboard bench for alu_retire_stage
module tb_alu_retire_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [31:0] in_flags;
    logic [2:0]  in_op;
    logic [2:0]  in_dst;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [2:0]  wb_dst;
    logic        wb_we;
    logic        flush;
    logic [31:0] eflags;
    logic        cf_fwd;
    logic        af_fwd;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  dst;
        logic        we;
    } wb_t;

    wb_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    alu_retire_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_op(in_op), .in_dst(in_dst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_dst(wb_dst), .wb_we(wb_we), .flush(flush),
        .eflags(eflags), .cf_fwd(cf_fwd), .af_fwd(af_fwd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] flg,
                         input logic [2:0] op, input logic [2:0] dst);
        in_valid  = v;
        in_result = res;
        in_flags  = flg;
        in_op     = op;
        in_dst    = dst;
    endtask

    task automatic issue(input logic [31:0] res, input logic [31:0] flg,
                         input logic [2:0] op, input logic [2:0] dst, input logic we);
        drive(1'b1, res, flg, op, dst);
        exp_q.push_back('{data: res, dst: dst, we: we});
    endtask

    // Monitor: every handshake that will retire at the next edge is checked against the scoreboard
    always @(negedge clk) begin
        if (reset_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected got data=%h dst=%0d exp=none", wb_data, wb_dst);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_dst", 32'(wb_dst), 32'(e.dst));
                check("wb_we", 32'(wb_we), 32'(e.we));
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        wb_ready = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst_eflags", eflags, 32'h2);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_cf_fwd", 32'(cf_fwd), 32'h0);
        check("rst_af_fwd", 32'(af_fwd), 32'h0);

        // Single ADD: result 5, flags CF|PF|AF, dst 2
        wb_ready = 1'b1;
        issue(32'h5, 32'h15, 3'd0, 3'd2, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        check("add_wb_valid", 32'(wb_valid), 32'h1);
        check("add_eflags_lat", eflags, 32'h2);
        tick();
        check("add_eflags", eflags, 32'h17);
        check("add_drained", 32'(wb_valid), 32'h0);

        // Full/backpressure: OR then AND, third request must be refused
        wb_ready = 1'b0;
        issue(32'hA, 32'h40, 3'd1, 3'd3, 1'b1);
        tick();
        check("full_ready1", 32'(in_ready), 32'h1);
        issue(32'hB, 32'h84, 3'd4, 3'd4, 1'b1);
        tick();
        check("full_ready2", 32'(in_ready), 32'h0);
        drive(1'b1, 32'hC, 32'h1, 3'd0, 3'd5);
        tick();
        check("full_ready3", 32'(in_ready), 32'h0);
        check("full_hold_data", wb_data, 32'hA);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        wb_ready = 1'b1;
        tick();
        check("full_ready_after_retire", 32'(in_ready), 32'h1);
        tick();
        check("full_drained", 32'(wb_valid), 32'h0);
        check("full_eflags", eflags, 32'h86);

        // Masking: STD touches DF only, NOT touches nothing
        wb_ready = 1'b0;
        issue(32'h11, 32'h401, 3'd7, 3'd1, 1'b0);
        tick();
        issue(32'hFFFF_FFEE, 32'hFFF, 3'd2, 3'd6, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        check("mask_cf_fwd", 32'(cf_fwd), 32'h0);
        check("mask_af_fwd", 32'(af_fwd), 32'h0);
        wb_ready = 1'b1;
        tick();
        tick();
        check("mask_eflags", eflags, 32'h486);

        // Forwarding: CF and AF visible before retirement
        wb_ready = 1'b0;
        issue(32'h7, 32'h11, 3'd0, 3'd0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        check("fwd_cf", 32'(cf_fwd), 32'h1);
        check("fwd_af", 32'(af_fwd), 32'h1);
        check("fwd_eflags_unretired", eflags, 32'h486);
        wb_ready = 1'b1;
        tick();
        check("fwd_eflags", eflags, 32'h413);

        // Flush with two entries and a same-cycle retire of CMP (ZF|CF)
        wb_ready = 1'b0;
        issue(32'h30, 32'h41, 3'd6, 3'd2, 1'b0);
        tick();
        issue(32'h31, 32'h880, 3'd0, 3'd3, 1'b1);
        tick();
        check("flush_pre_cf", 32'(cf_fwd), 32'h0);
        drive(1'b1, 32'h99, 32'h1, 3'd1, 3'd7);
        flush    = 1'b1;
        wb_ready = 1'b1;
        tick();
        exp_q.delete();
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        check("flush_wb_valid", 32'(wb_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        check("flush_eflags", eflags, 32'h443);
        check("flush_spec_cf", 32'(cf_fwd), 32'h1);
        check("flush_spec_af", 32'(af_fwd), 32'h0);

        // Flush with one entry while a real accept is offered: accept dropped, spec resynced
        issue(32'h50, 32'h10, 3'd0, 3'd4, 1'b1);
        tick();
        check("flush2_af_pre", 32'(af_fwd), 32'h1);
        drive(1'b1, 32'h51, 32'h1, 3'd0, 3'd5);
        flush = 1'b1;
        tick();
        exp_q.delete();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        check("flush2_wb_valid", 32'(wb_valid), 32'h0);
        check("flush2_af", 32'(af_fwd), 32'h0);
        check("flush2_cf", 32'(cf_fwd), 32'h1);
        check("flush2_eflags", eflags, 32'h443);
        wb_ready = 1'b1;
        repeat (3) tick();
        check("flush2_idle_valid", 32'(wb_valid), 32'h0);

        // Asynchronous reset in the middle of a drain
        wb_ready = 1'b0;
        issue(32'h60, 32'h800, 3'd0, 3'd1, 1'b1);
        tick();
        issue(32'h61, 32'h4, 3'd1, 3'd2, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'd0, 3'd0);
        wb_ready = 1'b1;
        tick();
        check("pre_rst_eflags", eflags, 32'hC02);
        check("pre_rst_valid", 32'(wb_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_wb_valid", 32'(wb_valid), 32'h0);
        check("arst_eflags", eflags, 32'h2);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", 32'(wb_valid), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
